multicycle_controller: RTL and testbench

Finite-state controller that sequences a shared-resource multicycle RV32I datapath: one ALU, one unified instruction/data memory port and one register file, reused across cycles.
- Decodes opcode, funct3 and funct7_5, then walks fetch/decode/execute/memory/writeback states.
- Drives every datapath select and enable.
- Waits on a memory ready handshake for every memory access.
- Latches a sticky trap on an unsupported opcode.

---
 rtl/multicycle_controller_if.sv | 15 +
 rtl/multicycle_controller.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller and the shared
// instruction/data memory port.
//   mem_req    controller -> memory : access requested this cycle
//   mem_write  controller -> memory : request is a store
//   adr_src    controller -> datapath address mux (0 = PC, 1 = ALU-out reg)
//   mem_ready  memory -> controller : current request completes this cycle
interface multicycle_controller_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for a shared-resource multicycle RV32I datapath (one ALU, one
// unified memory port, one register file).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   opcode_i, funct3_i, funct7_5_i   instruction register fields
//   zero_i            ALU zero flag (same cycle)
//   mem_if            memory handshake (mem_req/mem_write/adr_src out, mem_ready in)
//   ir_write_o, pc_write_o, reg_write_o       datapath write enables
//   alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o, alu_control_o  selects
//   illegal_instr_o   sticky trap flag, cleared only by reset
//   state_o           current state, for debug
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [6:0]                    opcode_i,
    input  logic [2:0]                    funct3_i,
    input  logic                          funct7_5_i,
    input  logic                          zero_i,
    multicycle_controller_if.master       mem_if,
    output logic                          ir_write_o,
    output logic                          pc_write_o,
    output logic                          reg_write_o,
    output logic [1:0]                    alu_src_a_o,
    output logic [1:0]                    alu_src_b_o,
    output logic [1:0]                    result_src_o,
    output logic [1:0]                    imm_src_o,
    output logic [2:0]                    alu_control_o,
    output logic                          illegal_instr_o,
    output logic [3:0]                    state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic       mem_req, mem_write, adr_src;
    logic       ir_write, pc_write, reg_write;
    logic [1:0] src_a, src_b, result_src;
    logic [2:0] alu_ctl;

    // Only R-type honours funct7_5 (sub); I-type has no subi so it is ignored.
    // Unknown funct3 falls back to add rather than trapping.
    function automatic logic [2:0] funct_alu(input logic is_r, input logic [2:0] f3,
                                             input logic f7_5);
        case (f3)
            3'b000:  funct_alu = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= state_t'(RESET_STATE);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        src_a      = 2'b00;
        src_b      = 2'b00;
        result_src = 2'b00;
        alu_ctl    = ALU_ADD;

        case (state_q)
            FETCH: begin
                // PC+4 goes straight from the ALU onto the result bus.
                mem_req    = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                if (mem_if.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                // Speculatively compute oldPC+imm so BEQ/JAL find it in ALU-out.
                src_a = 2'b01;
                src_b = 2'b01;
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_JAL:            state_d = JAL;
                    OP_BRANCH:         state_d = BEQ;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = (opcode_i == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_if.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_if.mem_ready) state_d = FETCH;
            end
            EXECUTER: begin
                src_a   = 2'b10;
                alu_ctl = funct_alu(1'b1, funct3_i, funct7_5_i);
                state_d = ALUWB;
            end
            EXECUTEI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_ctl = funct_alu(1'b0, funct3_i, funct7_5_i);
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                // Target is already in ALU-out; the ALU makes oldPC+4 for ALUWB.
                src_a    = 2'b01;
                src_b    = 2'b10;
                pc_write = 1'b1;
                state_d  = ALUWB;
            end
            BEQ: begin
                src_a    = 2'b10;
                alu_ctl  = ALU_SUB;
                pc_write = zero_i;
                state_d  = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = FETCH;
        endcase

        illegal_d = illegal_q | (state_d == TRAP);
    end

    always_comb begin
        case (opcode_i)
            OP_STORE:  imm_src_o = 2'b01;
            OP_BRANCH: imm_src_o = 2'b10;
            OP_JAL:    imm_src_o = 2'b11;
            default:   imm_src_o = 2'b00;
        endcase
    end

    assign mem_if.mem_req   = mem_req;
    assign mem_if.mem_write = mem_write;
    assign mem_if.adr_src   = adr_src;
    assign ir_write_o       = ir_write;
    assign pc_write_o       = pc_write;
    assign reg_write_o      = reg_write;
    assign alu_src_a_o      = src_a;
    assign alu_src_b_o      = src_b;
    assign result_src_o     = result_src;
    assign alu_control_o    = alu_ctl;
    assign illegal_instr_o  = illegal_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5, zero, mem_ready;
    logic       ir_write, pc_write, reg_write, illegal;
    logic [1:0] src_a, src_b, result_src, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_controller_if mif();
    assign mif.mem_ready = mem_ready;

    multicycle_controller dut (
        .clk(clk), .rst(rst),
        .opcode_i(opcode), .funct3_i(funct3), .funct7_5_i(funct7_5), .zero_i(zero),
        .mem_if(mif),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .reg_write_o(reg_write),
        .alu_src_a_o(src_a), .alu_src_b_o(src_b), .result_src_o(result_src),
        .imm_src_o(imm_src), .alu_control_o(alu_control),
        .illegal_instr_o(illegal), .state_o(state)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       req, wr, adr, irw, pcw, rgw;
        logic [1:0] a, b, res, imm;
        logic [2:0] alu;
    } ctl_t;

    int m_state;
    bit m_ill;
    bit chk_en = 1'b0;

    // Instruction-class flow: which step follows which.
    function automatic int mnext(int st, logic [6:0] op, logic mr);
        case (st)
            0:  return mr ? 1 : 0;
            1:  case (op)
                    7'h03, 7'h23: return 2;
                    7'h33: return 6;
                    7'h13: return 8;
                    7'h6F: return 9;
                    7'h63: return 10;
                    default: return 11;
                endcase
            2:  return (op == 7'h03) ? 3 : 5;
            3:  return mr ? 4 : 3;
            5:  return mr ? 0 : 5;
            6, 8, 9: return 7;
            11: return 11;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] malu(bit is_r, logic [2:0] f3, logic f75);
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b000 && is_r && f75) return 3'b001;
        return 3'b000;
    endfunction

    function automatic ctl_t mexp(int st, logic [6:0] op, logic [2:0] f3, logic f75,
                                  logic z, logic mr);
        ctl_t e = '0;
        e.imm = (op == 7'h23) ? 2'b01 : (op == 7'h63) ? 2'b10 : (op == 7'h6F) ? 2'b11 : 2'b00;
        case (st)
            0:  begin e.req = 1; e.b = 2; e.res = 2; e.irw = mr; e.pcw = mr; end
            1:  begin e.a = 1; e.b = 1; end
            2:  begin e.a = 2; e.b = 1; end
            3:  begin e.req = 1; e.adr = 1; end
            4:  begin e.res = 1; e.rgw = 1; end
            5:  begin e.req = 1; e.wr = 1; e.adr = 1; end
            6:  begin e.a = 2; e.alu = malu(1, f3, f75); end
            7:  e.rgw = 1;
            8:  begin e.a = 2; e.b = 1; e.alu = malu(0, f3, f75); end
            9:  begin e.a = 1; e.b = 2; e.pcw = 1; end
            10: begin e.a = 2; e.alu = 3'b001; e.pcw = z; end
            default: ;
        endcase
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
            m_ill   <= 1'b0;
        end else begin
            m_state <= mnext(m_state, opcode, mem_ready);
            if (mnext(m_state, opcode, mem_ready) == 11) m_ill <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            ctl_t e;
            e = mexp(m_state, opcode, funct3, funct7_5, zero, mem_ready);
            check("state",      32'(state),       32'(m_state));
            check("illegal",    32'(illegal),     32'(m_ill));
            check("mem_req",    32'(mif.mem_req), 32'(e.req));
            check("mem_write",  32'(mif.mem_write), 32'(e.wr));
            check("adr_src",    32'(mif.adr_src), 32'(e.adr));
            check("ir_write",   32'(ir_write),    32'(e.irw));
            check("pc_write",   32'(pc_write),    32'(e.pcw));
            check("reg_write",  32'(reg_write),   32'(e.rgw));
            check("alu_src_a",  32'(src_a),       32'(e.a));
            check("alu_src_b",  32'(src_b),       32'(e.b));
            check("result_src", 32'(result_src),  32'(e.res));
            check("imm_src",    32'(imm_src),     32'(e.imm));
            check("alu_ctl",    32'(alu_control), 32'(e.alu));
        end
    end

    // ---------------- directed stimulus ----------------
    int trace[$];
    int expq[$];
    int n_irw, n_pcw, n_regw, n_memw, n_req, n_ill, irw_at, alu_exec, imm_or;

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic z, input int fwait, input int mwait,
                             input int maxcyc, input bit stop_at_fetch);
        int cnt = 0;
        int prev;
        trace.delete();
        n_irw = 0; n_pcw = 0; n_regw = 0; n_memw = 0; n_req = 0; n_ill = 0;
        irw_at = -1; alu_exec = -1; imm_or = 0;
        opcode = op; funct3 = f3; funct7_5 = f75; zero = z;
        for (int c = 0; c < maxcyc; c++) begin
            if (m_state == 0)                      mem_ready = (cnt >= fwait);
            else if (m_state == 3 || m_state == 5) mem_ready = (cnt >= mwait);
            else                                   mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            trace.push_back(int'(state));
            n_irw  += int'(ir_write);
            n_pcw  += int'(pc_write);
            n_regw += int'(reg_write);
            n_memw += int'(mif.mem_write);
            n_req  += int'(mif.mem_req);
            n_ill  += int'(illegal);
            imm_or |= int'(imm_src);
            if (ir_write) irw_at = c;
            if (state == 4'd6 || state == 4'd8) alu_exec = int'(alu_control);
            prev = m_state;
            @(posedge clk); #1;
            cnt = (m_state == prev) ? cnt + 1 : 0;
            if (stop_at_fetch && m_state == 0 && prev != 0) break;
        end
        trace.push_back(int'(state));
    endtask

    task automatic check_trace(input string nm);
        check({nm, "_len"}, 32'(trace.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < trace.size(); i++)
            check(nm, 32'(trace[i]), 32'(expq[i]));
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_state",   32'(state),       32'd0);
        check("rst_illegal", 32'(illegal),     32'd0);
        check("rst_regw",    32'(reg_write),   32'd0);
        check("rst_memreq",  32'(mif.mem_req), 32'd1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; opcode = 7'h13; funct3 = 3'b000; funct7_5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        do_reset();

        // fetch stall, then addi with funct7_5=1 (still add)
        run_instr(7'h13, 3'b000, 1'b1, 1'b0, 3, 0, 20, 1);
        expq = {0, 0, 0, 0, 1, 8, 7, 0}; check_trace("stall_trace");
        check("stall_memreq", 32'(n_req), 32'd4);
        check("stall_irw",    32'(n_irw), 32'd1);
        check("stall_pcw",    32'(n_pcw), 32'd1);
        check("stall_irw_at", 32'(irw_at), 32'd3);
        check("addi_alu",     32'(alu_exec), 32'd0);

        // lw, memory always ready
        run_instr(7'h03, 3'b010, 1'b0, 1'b0, 0, 0, 20, 1);
        expq = {0, 1, 2, 3, 4, 0}; check_trace("lw_trace");
        check("lw_regw", 32'(n_regw), 32'd1);
        check("lw_imm",  32'(imm_or), 32'd0);

        // sw, memory ready on second cycle
        run_instr(7'h23, 3'b010, 1'b0, 1'b0, 0, 1, 20, 1);
        expq = {0, 1, 2, 5, 5, 0}; check_trace("sw_trace");
        check("sw_memw", 32'(n_memw), 32'd2);
        check("sw_regw", 32'(n_regw), 32'd0);
        check("sw_imm",  32'(imm_or), 32'd1);

        // R-type funct decode
        run_instr(7'h33, 3'b000, 1'b1, 1'b0, 0, 0, 20, 1);
        expq = {0, 1, 6, 7, 0}; check_trace("sub_trace");
        check("sub_alu",  32'(alu_exec), 32'd1);
        check("sub_regw", 32'(n_regw), 32'd1);
        run_instr(7'h33, 3'b110, 1'b0, 1'b0, 1, 0, 20, 1);
        check("or_alu", 32'(alu_exec), 32'd3);
        run_instr(7'h33, 3'b111, 1'b1, 1'b0, 0, 0, 20, 1);
        check("and_alu", 32'(alu_exec), 32'd2);
        run_instr(7'h13, 3'b010, 1'b1, 1'b0, 0, 0, 20, 1);
        check("slti_alu", 32'(alu_exec), 32'd5);
        run_instr(7'h33, 3'b001, 1'b1, 1'b0, 0, 0, 20, 1);
        check("f3_001_alu", 32'(alu_exec), 32'd0);

        // beq taken / not taken
        run_instr(7'h63, 3'b000, 1'b0, 1'b1, 0, 0, 20, 1);
        expq = {0, 1, 10, 0}; check_trace("beq_trace");
        check("beq_taken_pcw", 32'(n_pcw), 32'd2);
        check("beq_imm",       32'(imm_or), 32'd2);
        run_instr(7'h63, 3'b000, 1'b0, 1'b0, 0, 0, 20, 1);
        check("beq_nt_pcw", 32'(n_pcw), 32'd1);

        // jal
        run_instr(7'h6F, 3'b000, 1'b0, 1'b0, 0, 0, 20, 1);
        expq = {0, 1, 9, 7, 0}; check_trace("jal_trace");
        check("jal_pcw",  32'(n_pcw), 32'd2);
        check("jal_regw", 32'(n_regw), 32'd1);

        // reset while waiting in MEMREAD
        run_instr(7'h03, 3'b010, 1'b0, 1'b0, 0, 100, 5, 1);
        expq = {0, 1, 2, 3, 3, 3}; check_trace("midwait_trace");
        do_reset();

        // illegal opcode: sticky trap
        run_instr(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0, 13, 0);
        check("trap_entry", 32'(trace[2]), 32'd11);
        check("trap_ill",   32'(n_ill), 32'd11);
        check("trap_req",   32'(n_req), 32'd1);
        check("trap_hold",  32'(trace[trace.size()-1]), 32'd11);
        opcode = 7'h13;
        do_reset();

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
